// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths, write-back select and flag-source encodings.
package pipe_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned RADDR_W = 3;

    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_SHIFT = 2'b01;
    localparam logic [1:0] WB_MEM   = 2'b10;

    localparam logic FLAG_ALU   = 1'b0;
    localparam logic FLAG_SHIFT = 1'b1;

    // Non-memory result; a load carries its address here, memory data is muxed downstream.
    function automatic logic [DATA_W-1:0] wb_result(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] shift
    );
        case (sel)
            WB_ALU, WB_MEM: return alu;
            WB_SHIFT:       return shift;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/cz_flag_reg.sv
// Architectural carry/zero flags with per-flag source select and independent write enables.
module cz_flag_reg
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic stall_i,
    input  logic commit_i,
    input  logic alu_c_i,
    input  logic alu_z_i,
    input  logic shift_c_i,
    input  logic shift_z_i,
    input  logic select_c_i,
    input  logic select_z_i,
    input  logic write_c_i,
    input  logic write_z_i,
    output logic c_o,
    output logic z_o
);

    logic c_q, c_d;
    logic z_q, z_d;

    always_comb begin
        c_d = c_q;
        z_d = z_q;
        if (commit_i && !stall_i) begin
            if (write_c_i) c_d = (select_c_i == FLAG_SHIFT) ? shift_c_i : alu_c_i;
            if (write_z_i) z_d = (select_z_i == FLAG_SHIFT) ? shift_z_i : alu_z_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= 1'b0;
            z_q <= 1'b0;
        end else begin
            c_q <= c_d;
            z_q <= z_d;
        end
    end

    assign c_o = c_q;
    assign z_o = z_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: latches EX results/control, commits C/Z, drives DataMem,
// reports forwarding/load-use status and counts retired instructions.
module ex_mem_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               ex_valid,
    input  logic [DATA_W-1:0]  ex_alu_out,
    input  logic [DATA_W-1:0]  ex_shift_out,
    input  logic [DATA_W-1:0]  ex_b,
    input  logic [RADDR_W-1:0] ex_dest,
    input  logic               ex_mem_write,
    input  logic               ex_reg_write,
    input  logic [1:0]         ex_reg_write_mux,
    input  logic               ex_alu_co,
    input  logic               ex_alu_z,
    input  logic               ex_shift_c,
    input  logic               ex_shift_z,
    input  logic               ex_select_c,
    input  logic               ex_select_z,
    input  logic               ex_write_c,
    input  logic               ex_write_z,
    output logic               mem_valid,
    output logic [DATA_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_write_data,
    output logic               mem_write,
    output logic [DATA_W-1:0]  mem_result,
    output logic [RADDR_W-1:0] mem_dest,
    output logic               mem_reg_write,
    output logic [1:0]         mem_reg_write_mux,
    output logic               C,
    output logic               Z,
    output logic               fwd_valid,
    output logic               load_use,
    output logic [CNT_W-1:0]   retired
);

    logic               valid_q,   valid_d;
    logic [DATA_W-1:0]  addr_q,    addr_d;
    logic [DATA_W-1:0]  wdata_q,   wdata_d;
    logic               mw_q,      mw_d;
    logic [DATA_W-1:0]  result_q,  result_d;
    logic [RADDR_W-1:0] dest_q,    dest_d;
    logic               rw_q,      rw_d;
    logic [1:0]         mux_q,     mux_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    // Flush and an empty EX slot both produce a bubble; stall holds everything.
    always_comb begin
        valid_d   = valid_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mw_d      = mw_q;
        result_d  = result_q;
        dest_d    = dest_q;
        rw_d      = rw_q;
        mux_d     = mux_q;
        retired_d = retired_q;
        if (flush || (!stall && !ex_valid)) begin
            valid_d  = 1'b0;
            addr_d   = '0;
            wdata_d  = '0;
            mw_d     = 1'b0;
            result_d = '0;
            dest_d   = '0;
            rw_d     = 1'b0;
            mux_d    = WB_ALU;
        end else if (!stall) begin
            valid_d   = 1'b1;
            addr_d    = ex_alu_out;
            wdata_d   = ex_b;
            mw_d      = ex_mem_write;
            result_d  = wb_result(ex_reg_write_mux, ex_alu_out, ex_shift_out);
            dest_d    = ex_dest;
            rw_d      = ex_reg_write;
            mux_d     = ex_reg_write_mux;
            retired_d = retired_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mw_q      <= 1'b0;
            result_q  <= '0;
            dest_q    <= '0;
            rw_q      <= 1'b0;
            mux_q     <= WB_ALU;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mw_q      <= mw_d;
            result_q  <= result_d;
            dest_q    <= dest_d;
            rw_q      <= rw_d;
            mux_q     <= mux_d;
            retired_q <= retired_d;
        end
    end

    cz_flag_reg u_cz_flag_reg (
        .clk        (clk),
        .reset      (reset),
        .stall_i    (stall),
        .commit_i   (ex_valid & ~flush),
        .alu_c_i    (ex_alu_co),
        .alu_z_i    (ex_alu_z),
        .shift_c_i  (ex_shift_c),
        .shift_z_i  (ex_shift_z),
        .select_c_i (ex_select_c),
        .select_z_i (ex_select_z),
        .write_c_i  (ex_write_c),
        .write_z_i  (ex_write_z),
        .c_o        (C),
        .z_o        (Z)
    );

    assign mem_valid         = valid_q;
    assign mem_addr          = addr_q;
    assign mem_write_data    = wdata_q;
    assign mem_write         = mw_q;
    assign mem_result        = result_q;
    assign mem_dest          = dest_q;
    assign mem_reg_write     = rw_q;
    assign mem_reg_write_mux = mux_q;
    assign retired           = retired_q;

    assign fwd_valid = valid_q & rw_q & (mux_q != WB_MEM);
    assign load_use  = valid_q & rw_q & (mux_q == WB_MEM);

endmodule
